// File: rtl/edge_pattern_gen_pkg.sv
// edge_gen_pkg: shared types and default widths for edge_pattern_gen.
//   state_e : FSM encoding (IDLE, HIGH, LOW)
//   cmd_t   : packed command {high, low, reps} at the default widths
package edge_gen_pkg;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_REP_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] high;
    logic [DEF_CNT_W-1:0] low;
    logic [DEF_REP_W-1:0] reps;
  } cmd_t;
endpackage

// File: rtl/edge_pattern_gen_down_counter.sv
// down_counter: loadable down-counter that saturates at zero.
//   clk, reset : clock, async active-high reset (count clears to 0)
//   load       : load load_val (takes priority over dec)
//   dec        : decrement by one; ignored at zero so it never wraps
//   zero       : count == 0
module down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/edge_pattern_gen.sv
// edge_pattern_gen: programmable square-wave generator.
//   cmd_valid_i/cmd_ready_o : command handshake; fields sampled only at handshake
//   cmd_high_i/cmd_low_i    : phase lengths in cycles (0 treated as 1)
//   cmd_reps_i              : number of high+low periods (0 -> immediate done)
//   a_o                     : generated level
//   rising_o/falling_o      : one-cycle markers on the first cycle of each phase
//   busy_o                  : waveform in progress
//   done_o                  : one-cycle completion pulse
// All outputs are registered; the next-cycle values are computed combinationally.
module edge_pattern_gen
  import edge_gen_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int REP_W = DEF_REP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [CNT_W-1:0] cmd_high_i,
  input  logic [CNT_W-1:0] cmd_low_i,
  input  logic [REP_W-1:0] cmd_reps_i,
  output logic             a_o,
  output logic             rising_o,
  output logic             falling_o,
  output logic             busy_o,
  output logic             done_o
);
  state_e           state, state_n;
  logic [CNT_W-1:0] high_q, low_q;
  logic             a_n, rise_n, fall_n, busy_n, done_n, ready_n;
  logic             ph_load, ph_dec, ph_zero;
  logic [CNT_W-1:0] ph_val;
  logic             rp_load, rp_dec, rp_zero;
  logic [REP_W-1:0] rp_val;
  logic             accept;

  // Phase counter holds "cycles left after this one", so a length of 0 and 1
  // both load 0 (the clamp).
  function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] x);
    return (x == '0) ? '0 : x - 1'b1;
  endfunction

  assign accept = cmd_valid_i && cmd_ready_o;

  down_counter #(.W(CNT_W)) u_phase (
    .clk(clk), .reset(reset), .load(ph_load), .load_val(ph_val),
    .dec(ph_dec), .zero(ph_zero)
  );

  down_counter #(.W(REP_W)) u_reps (
    .clk(clk), .reset(reset), .load(rp_load), .load_val(rp_val),
    .dec(rp_dec), .zero(rp_zero)
  );

  always_comb begin
    state_n = state;
    a_n     = 1'b0;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    ready_n = 1'b1;
    ph_load = 1'b0;
    ph_dec  = 1'b0;
    ph_val  = '0;
    rp_load = 1'b0;
    rp_dec  = 1'b0;
    rp_val  = '0;
    unique case (state)
      IDLE: begin
        if (accept && cmd_reps_i != '0) begin
          state_n = HIGH;
          a_n     = 1'b1;
          rise_n  = 1'b1;
          busy_n  = 1'b1;
          ready_n = 1'b0;
          ph_load = 1'b1;
          ph_val  = len_m1(cmd_high_i);
          rp_load = 1'b1;
          rp_val  = cmd_reps_i - 1'b1;
        end else if (accept) begin
          done_n = 1'b1;
        end
      end
      HIGH: begin
        busy_n  = 1'b1;
        ready_n = 1'b0;
        if (ph_zero) begin
          state_n = LOW;
          fall_n  = 1'b1;
          ph_load = 1'b1;
          ph_val  = len_m1(low_q);
        end else begin
          a_n    = 1'b1;
          ph_dec = 1'b1;
        end
      end
      LOW: begin
        busy_n  = 1'b1;
        ready_n = 1'b0;
        if (ph_zero && rp_zero) begin
          // Ready is raised in the done cycle so a follow-on command can be
          // taken without an extra idle cycle.
          state_n = IDLE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          ready_n = 1'b1;
        end else if (ph_zero) begin
          state_n = HIGH;
          a_n     = 1'b1;
          rise_n  = 1'b1;
          rp_dec  = 1'b1;
          ph_load = 1'b1;
          ph_val  = len_m1(high_q);
        end else begin
          ph_dec = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      a_o         <= 1'b0;
      rising_o    <= 1'b0;
      falling_o   <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      cmd_ready_o <= 1'b1;
      high_q      <= '0;
      low_q       <= '0;
    end else begin
      state       <= state_n;
      a_o         <= a_n;
      rising_o    <= rise_n;
      falling_o   <= fall_n;
      busy_o      <= busy_n;
      done_o      <= done_n;
      cmd_ready_o <= ready_n;
      if (accept) begin
        high_q <= cmd_high_i;
        low_q  <= cmd_low_i;
      end
    end
  end
endmodule
